// File: rtl/pe_array_sequencer_if.sv
// Control bundle between the layer controller / input data buffer and the PE array sequencer.
// The master side drives config, start and in_valid; the sequencer (slave) drives everything else.
interface pe_array_sequencer_if #(
   parameter int N_PE      = 8,
   parameter int ADDR_FIFO = 10
);
   logic                   start;
   logic [ADDR_FIFO-1:0]   row_length;
   logic [2:0]             kernel_size;
   logic [15:0]            n_rows;
   logic [N_PE-1:0]        active_cols;
   logic                   accumulate;
   logic [2:0]             nl_type;
   logic                   final_bank_in;
   logic                   in_valid;
   logic                   in_ready;
   logic [N_PE*N_PE-1:0]   shifting_filter;
   logic [N_PE*N_PE-1:0]   shifting_line;
   logic [N_PE*N_PE-1:0]   mac_enable;
   logic                   line_buffer_reset;
   logic [ADDR_FIFO-1:0]   row_length_out;
   logic [N_PE-1:0]        adder_enable;
   logic [N_PE-1:0]        feedback_enable;
   logic [N_PE-1:0]        nl_enable;
   logic                   final_filter_bank;
   logic                   busy;
   logic                   done;
   logic                   cfg_err;

   modport master (
      output start, row_length, kernel_size, n_rows, active_cols, accumulate, nl_type,
             final_bank_in, in_valid,
      input  in_ready, shifting_filter, shifting_line, mac_enable, line_buffer_reset,
             row_length_out, adder_enable, feedback_enable, nl_enable, final_filter_bank,
             busy, done, cfg_err
   );

   modport slave (
      input  start, row_length, kernel_size, n_rows, active_cols, accumulate, nl_type,
             final_bank_in, in_valid,
      output in_ready, shifting_filter, shifting_line, mac_enable, line_buffer_reset,
             row_length_out, adder_enable, feedback_enable, nl_enable, final_filter_bank,
             busy, done, cfg_err
   );
endinterface

// File: rtl/pe_array_sequencer.sv
// Sequences one convolution pass over the PE array: line-buffer reset, filter load,
// line priming and streaming/MAC, paced by the in_valid/in_ready handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; illegal config pulses cfg_err
// LB_RST   | one-cycle line_buffer_reset, counters loaded
// FLOAD    | K*K filter beats, shifting_filter on active PEs
// PRIME    | (K-1)*W line beats, no MAC
// STREAM   | (H-K+1) rows of W beats, MAC once column x >= K-1
// DRAIN    | MAC_LAT+1 cycles for the adder pipeline to empty
// DONE     | one-cycle done pulse
module pe_array_sequencer #(
   parameter int N_PE      = 8,
   parameter int ADDR_FIFO = 10,
   parameter int MAC_LAT   = 1
) (
   input logic                  clk,
   input logic                  rst,
   pe_array_sequencer_if.slave  bus
);

   localparam int NPE2 = N_PE * N_PE;

   typedef enum logic [2:0] {
      S_IDLE, S_LB_RST, S_FLOAD, S_PRIME, S_STREAM, S_DRAIN, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_FIFO-1:0] w_q;
   logic [2:0]           k_q;
   logic [15:0]          h_q;
   logic [N_PE-1:0]      m_q;
   logic                 acc_q;
   logic [2:0]           nl_type_q;
   logic                 fb_q;

   logic [15:0]          beat_cnt;
   logic [15:0]          row_cnt;
   logic [ADDR_FIFO-1:0] x_cnt;

   logic                 cfg_bad;
   logic                 accept;
   logic                 ready_i;
   logic                 beat;
   logic                 beat_tc;
   logic                 x_last;
   logic                 row_tc;
   logic                 mac_col_ok;
   logic                 cfg_err_q;
   logic [15:0]          fload_len;
   logic [15:0]          prime_len;
   logic [NPE2-1:0]      pe_mask;
   logic [N_PE-1:0]      col_mac;
   logic [N_PE-1:0]      nl_q;
   logic [N_PE-1:0]      adder_pipe [MAC_LAT];

   always_comb begin
      cfg_bad = (bus.kernel_size == 3'd0)
             || (32'(bus.kernel_size) > N_PE)
             || (32'(bus.row_length) < 32'(bus.kernel_size))
             || (32'(bus.n_rows) < 32'(bus.kernel_size))
             || (bus.active_cols == '0);
   end

   assign accept     = (state == S_IDLE) && bus.start && !cfg_bad;
   assign ready_i    = (state == S_FLOAD) || (state == S_PRIME) || (state == S_STREAM);
   assign beat       = bus.in_valid && ready_i;
   assign beat_tc    = (beat_cnt == '0);
   assign x_last     = (x_cnt == w_q - ADDR_FIFO'(1));
   assign row_tc     = (row_cnt == '0);
   assign mac_col_ok = (32'(x_cnt) + 32'd1) >= 32'(k_q);
   // Terminal counts are loaded as length-1 so the down-counter ends on zero.
   assign fload_len  = 16'(k_q) * 16'(k_q) - 16'd1;
   assign prime_len  = 16'(k_q - 3'd1) * 16'(w_q) - 16'd1;

   always_comb begin
      pe_mask = '0;
      for (int r = 0; r < N_PE; r++) begin
         for (int c = 0; c < N_PE; c++) begin
            pe_mask[r*N_PE + c] = (r < 32'(k_q)) && m_q[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_LB_RST;
         S_LB_RST: state_nxt = S_FLOAD;
         S_FLOAD:  if (beat && beat_tc) state_nxt = (k_q == 3'd1) ? S_STREAM : S_PRIME;
         S_PRIME:  if (beat && beat_tc) state_nxt = S_STREAM;
         S_STREAM: if (beat && x_last && row_tc) state_nxt = S_DRAIN;
         S_DRAIN:  if (beat_tc) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready          = ready_i;
      bus.line_buffer_reset = (state == S_LB_RST);
      bus.busy              = (state != S_IDLE);
      bus.done              = (state == S_DONE);
      bus.shifting_filter   = '0;
      bus.shifting_line     = '0;
      bus.mac_enable        = '0;
      if (beat) begin
         case (state)
            S_FLOAD:  bus.shifting_filter = pe_mask;
            S_PRIME:  bus.shifting_line   = pe_mask;
            S_STREAM: begin
               bus.shifting_line = pe_mask;
               if (mac_col_ok) bus.mac_enable = pe_mask;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_q       <= '0;
         k_q       <= '0;
         h_q       <= '0;
         m_q       <= '0;
         acc_q     <= 1'b0;
         nl_type_q <= '0;
         fb_q      <= 1'b0;
         beat_cnt  <= '0;
         row_cnt   <= '0;
         x_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  w_q       <= bus.row_length;
                  k_q       <= bus.kernel_size;
                  h_q       <= bus.n_rows;
                  m_q       <= bus.active_cols;
                  acc_q     <= bus.accumulate;
                  nl_type_q <= bus.nl_type;
                  fb_q      <= bus.final_bank_in;
               end
            end
            S_LB_RST: begin
               beat_cnt <= fload_len;
               x_cnt    <= '0;
               row_cnt  <= h_q - 16'(k_q);
            end
            S_FLOAD: begin
               if (beat) beat_cnt <= beat_tc ? prime_len : beat_cnt - 16'd1;
            end
            S_PRIME: begin
               if (beat && !beat_tc) beat_cnt <= beat_cnt - 16'd1;
            end
            S_STREAM: begin
               // Beat counter is idle here; preload it with the drain length.
               beat_cnt <= 16'(MAC_LAT);
               if (beat) begin
                  if (x_last) begin
                     x_cnt <= '0;
                     if (!row_tc) row_cnt <= row_cnt - 16'd1;
                  end else begin
                     x_cnt <= x_cnt + ADDR_FIFO'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (!beat_tc) beat_cnt <= beat_cnt - 16'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= (state == S_IDLE) && bus.start && cfg_bad;
      end
   end

   always_comb begin
      col_mac = '0;
      for (int r = 0; r < N_PE; r++) begin
         for (int c = 0; c < N_PE; c++) begin
            col_mac[c] = col_mac[c] | bus.mac_enable[r*N_PE + c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAC_LAT; i++) adder_pipe[i] <= '0;
         nl_q <= '0;
      end else begin
         adder_pipe[0] <= col_mac;
         for (int i = 1; i < MAC_LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
         nl_q <= (nl_type_q != 3'd0) ? adder_pipe[MAC_LAT-1] : '0;
      end
   end

   assign bus.adder_enable      = adder_pipe[MAC_LAT-1];
   assign bus.feedback_enable   = adder_pipe[MAC_LAT-1] & {N_PE{acc_q}};
   assign bus.nl_enable         = nl_q;
   assign bus.row_length_out    = w_q;
   assign bus.final_filter_bank = fb_q;
   assign bus.cfg_err           = cfg_err_q;

endmodule

// File: doc/pe_array_sequencer.md
# pe_array_sequencer

Control-side driver of the PE array control bundle. It runs one convolution pass per `start`: one-cycle line-buffer reset, filter load, line-buffer priming, then the streaming/MAC phase. It generates per-PE `shifting_filter`, `shifting_line` and `mac_enable`, plus per-column `adder_enable`, `feedback_enable` and `nl_enable`, paced by a valid/ready handshake with the input data buffer. It sits between the layer controller and the PE array.

## Interface
- `N_PE`, 8, PE grid dimension (rows = columns)
- `ADDR_FIFO`, 10, width of `row_length`
- `MAC_LAT`, 1, cycles from `mac_enable` to column `adder_enable`
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  launch pass; sampled only in IDLE
- `row_length`  in  ADDR_FIFO  pixels per input row (W)
- `kernel_size`  in  3  K, legal 1..N_PE
- `n_rows`  in  16  input rows (H)
- `active_cols`  in  N_PE  filter columns in use
- `accumulate`  in  1  add partial sums fed back from the previous bank
- `nl_type`  in  3  0 = no nonlinearity
- `final_bank_in`  in  1  this pass is the last filter bank
- `in_valid`  in  1  data/filter word present on the input buses
- `in_ready`  out  1  sequencer accepts a word this cycle
- `shifting_filter`  out  N_PE*N_PE  bit r*N_PE+c = PE(r,c)
- `shifting_line`  out  N_PE*N_PE  same indexing
- `mac_enable`  out  N_PE*N_PE  same indexing
- `line_buffer_reset`  out  1
- `row_length_out`  out  ADDR_FIFO  latched W
- `adder_enable`, `feedback_enable`, `nl_enable`  out  N_PE each
- `final_filter_bank`  out  1  latched `final_bank_in`
- `busy`  out  1;  `done`  out  1 (pulse);  `cfg_err`  out  1 (pulse)

## Operation
- Config is latched on the accepted `start`. The mask is M = `active_cols`; rows r < K are active.
- Beat = cycle with `in_valid & in_ready`. All shift/MAC outputs are combinational from state/counters and gated by beat. No shifting happens without a beat.
- States:
  - IDLE: `in_ready`=0. A `start` with a legal config goes to LB_RST.
  - Illegal config (K=0, K>N_PE, W<K, H<K, M=0): stay in IDLE and pulse `cfg_err` for 1 cycle.
  - LB_RST: `line_buffer_reset`=1 for exactly 1 cycle, counters cleared, then FLOAD.
  - FLOAD: `in_ready`=1. On each beat, `shifting_filter`=1 for active rows × M. After K*K beats, go to PRIME.
  - PRIME: `in_ready`=1. On each beat, `shifting_line`=1 for active rows × M and `mac_enable`=0. After (K-1)*W beats, go to STREAM. For K=1, skip directly to STREAM.
  - STREAM: `in_ready`=1. On each beat, `shifting_line` is as in PRIME. `mac_enable`=`shifting_line` when the column counter x ≥ K-1, where x runs 0..W-1 and wraps. After W beats the row counter increments. After (H-K+1) rows, go to DRAIN.
  - DRAIN: `in_ready`=0 for MAC_LAT+1 cycles, then DONE.
  - DONE: `done`=1 for 1 cycle, then IDLE.
- `adder_enable[c]` = OR over r of `mac_enable[r][c]`, delayed MAC_LAT cycles.
- `feedback_enable` = `adder_enable` & {N_PE{`accumulate`}}.
- `nl_enable` = `adder_enable` delayed 1 cycle when `nl_type`≠0, else 0.
- `busy`=1 in all states except IDLE.
- `start` while busy is ignored. Config inputs may change freely after the accepted `start`.

## Timing
- Reset: state=IDLE, counters=0, delay lines cleared. Every output is 0, including `row_length_out` and `final_filter_bank`.
- Reset mid-pass aborts to IDLE on the next edge. No `done` is emitted and no output stays asserted.
- With `in_valid` held high, total latency from `start` to `done` is 1 + 1 + K² + (K-1)W + (H-K+1)W + MAC_LAT + 1 cycles.
- When `in_valid` is low, all counters hold and all shift/MAC outputs are 0. The pipelined `adder_enable`/`nl_enable` continue to drain.
- Counter widths: beat counter 16 bit, row counter 16 bit. No wrap occurs within legal configs.

## Test plan
- Nominal pass, K=3, W=5, H=5, M=all-ones, `in_valid`=1, `start` at cycle 0:
  - LB_RST at cycle 1.
  - FLOAD at cycles 2–10 (9 beats).
  - PRIME at cycles 11–20.
  - STREAM at cycles 21–35, with `mac_enable` rows 0–2 high at x=2,3,4 (9 pulses).
  - `adder_enable` high 1 cycle after each MAC pulse, last at cycle 36.
  - `done` at cycle 38.
- Backpressure, same config with `in_valid` toggling 1/0: beat counts and MAC count are unchanged. No shift/MAC is asserted while `in_valid`=0, and `done` arrives later than in the nominal pass.
- Illegal configs:
  - K=0: `cfg_err` pulses 1 cycle, `busy` stays 0.
  - W=2 with K=3: same response.
  - M=0: same response.
- K=1, W=4, H=2, M=8'b0000_0101, `nl_type`=1, `accumulate`=1:
  - No PRIME beats; 8 MAC beats in columns 0 and 2 only.
  - `feedback_enable` equals `adder_enable`.
  - `nl_enable` lags `adder_enable` by 1 cycle.
- Start ignored and reset mid-pass:
  - `start` pulsed during STREAM has no effect.
  - `rst` asserted during PRIME: all outputs are 0 on the next cycle, and a new `start` runs a full pass normally.
